// File: rtl/absorb_unit.sv
// absorb_unit: Keccak sponge absorb front-end. Packs byte-enabled message
// beats into the rate portion of a 1600-bit state, requests an external
// permutation whenever a rate block is full, applies SHA3/SHAKE padding
// and pulses done_o once the final block has been permuted.
// Build option: define ABSORB_SHAKE_EN to enable SHAKE128/SHAKE256 (modes 4/5).
module absorb_unit #(
  parameter int DWIDTH     = 64,
  parameter int KEEP_WIDTH = DWIDTH / 8
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [2:0]            mode_i,
  input  logic [DWIDTH-1:0]     msg_i,
  input  logic [KEEP_WIDTH-1:0] keep_i,
  input  logic                  valid_i,
  input  logic                  last_i,
  output logic                  ready_o,
  output logic [1599:0]         state_o,
  output logic                  perm_req_o,
  input  logic                  perm_done_i,
  input  logic [1599:0]         perm_state_i,
  output logic                  done_o,
  output logic                  mode_err_o
);

  localparam int SW = 1600;
  localparam int NB = SW / 8;

  typedef enum logic [2:0] {
    S_IDLE, S_ABSORB, S_CARRY, S_PAD, S_PERM_WAIT, S_DONE
  } fsm_t;

  fsm_t                  fsm_reg, fsm_next;
  logic [SW-1:0]         state_reg;
  logic [7:0]            cnt_reg;
  logic [2:0]            mode_reg;
  logic [DWIDTH-1:0]     carry_data_reg;
  logic [KEEP_WIDTH-1:0] carry_keep_reg;
  logic                  carry_last_reg;
  logic                  carry_pend_reg;
  logic                  pad_pend_reg;
  logic                  final_reg;
  logic                  alive_reg;
  logic                  mode_err_reg;

  function automatic logic [7:0] rate_of(input logic [2:0] m);
    case (m)
      3'd0:    return 8'd144;
      3'd1:    return 8'd136;
      3'd2:    return 8'd104;
      3'd3:    return 8'd72;
`ifdef ABSORB_SHAKE_EN
      3'd4:    return 8'd168;
      3'd5:    return 8'd136;
`endif
      default: return 8'd0;
    endcase
  endfunction

  function automatic logic mode_legal(input logic [2:0] m);
`ifdef ABSORB_SHAKE_EN
    return m <= 3'd5;
`else
    return m <= 3'd3;
`endif
  endfunction

  // keep_i is contiguous from bit 0, so the popcount is the byte count
  function automatic logic [7:0] popcnt(input logic [KEEP_WIDTH-1:0] k);
    logic [7:0] c;
    c = '0;
    for (int i = 0; i < KEEP_WIDTH; i++) c = c + {7'd0, k[i]};
    return c;
  endfunction

  logic                  in_idle;
  logic                  accept;
  logic                  beat_ok;
  logic [2:0]            cur_mode;
  logic [7:0]            rate;
  logic [7:0]            base_cnt;
  logic [8:0]            sum_cnt;
  logic [7:0]            room;
  logic                  straddle;
  logic                  fill;
  logic [DWIDTH-1:0]     msg_masked;
  logic [SW-1:0]         beat_wide;
  logic [SW-1:0]         rate_mask;
  logic [SW-1:0]         absorb_vec;
  logic [DWIDTH-1:0]     carry_data;
  logic [KEEP_WIDTH-1:0] carry_keep;
  logic [7:0]            domain;
  logic [SW-1:0]         pad_vec;

  assign in_idle  = (fsm_reg == S_IDLE);
  assign ready_o  = alive_reg && (in_idle || fsm_reg == S_ABSORB);
  assign accept   = valid_i && ready_o;
  // mode_i only matters for the first beat; afterwards the latched mode rules
  assign beat_ok  = accept && (!in_idle || mode_legal(mode_i));
  assign cur_mode = in_idle ? mode_i : mode_reg;
  assign rate     = rate_of(cur_mode);
  assign base_cnt = in_idle ? 8'd0 : cnt_reg;
  assign sum_cnt  = {1'b0, base_cnt} + {1'b0, popcnt(keep_i)};
  assign room     = rate - base_cnt;
  assign straddle = sum_cnt > {1'b0, rate};
  assign fill     = sum_cnt == {1'b0, rate};

  for (genvar gi = 0; gi < KEEP_WIDTH; gi++) begin : g_mask
    assign msg_masked[8*gi +: 8] = keep_i[gi] ? msg_i[8*gi +: 8] : 8'h00;
  end

  for (genvar gi = 0; gi < NB; gi++) begin : g_rate
    assign rate_mask[8*gi +: 8] = (gi < int'(rate)) ? 8'hFF : 8'h00;
  end

  // Bytes beyond the rate boundary are dropped here and re-applied from the carry register
  assign beat_wide  = SW'(msg_masked) << {base_cnt, 3'b000};
  assign absorb_vec = beat_wide & rate_mask;
  assign carry_data = msg_masked >> {room, 3'b000};
  assign carry_keep = keep_i >> room;

`ifdef ABSORB_SHAKE_EN
  assign domain = (mode_reg >= 3'd4) ? 8'h1F : 8'h06;
`else
  assign domain = 8'h06;
`endif
  // XOR of both pad bytes merges into 0x86/0x9F when they land on the same byte
  assign pad_vec = (SW'(domain) << {cnt_reg, 3'b000}) ^ (SW'(8'h80) << {rate - 8'd1, 3'b000});

  assign state_o    = state_reg;
  assign perm_req_o = (fsm_reg == S_PERM_WAIT);
  assign done_o     = (fsm_reg == S_DONE);
  assign mode_err_o = mode_err_reg;

  // FSM state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) fsm_reg <= S_IDLE;
    else        fsm_reg <= fsm_next;
  end

  // Next-state decode
  always_comb begin
    fsm_next = fsm_reg;
    case (fsm_reg)
      S_IDLE, S_ABSORB: begin
        if (beat_ok) begin
          if (straddle || fill) fsm_next = S_PERM_WAIT;
          else if (last_i)      fsm_next = S_PAD;
          else                  fsm_next = S_ABSORB;
        end
      end
      S_CARRY:     fsm_next = carry_last_reg ? S_PAD : S_ABSORB;
      S_PAD:       fsm_next = S_PERM_WAIT;
      S_PERM_WAIT: begin
        if (perm_done_i) begin
          if (final_reg)           fsm_next = S_DONE;
          else if (carry_pend_reg) fsm_next = S_CARRY;
          else if (pad_pend_reg)   fsm_next = S_PAD;
          else                     fsm_next = S_ABSORB;
        end
      end
      S_DONE:      fsm_next = S_IDLE;
      default:     fsm_next = S_IDLE;
    endcase
  end

  // Datapath: state XOR, byte counter, carry and block-sequencing flags
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg      <= '0;
      cnt_reg        <= '0;
      mode_reg       <= '0;
      carry_data_reg <= '0;
      carry_keep_reg <= '0;
      carry_last_reg <= 1'b0;
      carry_pend_reg <= 1'b0;
      pad_pend_reg   <= 1'b0;
      final_reg      <= 1'b0;
      alive_reg      <= 1'b0;
      mode_err_reg   <= 1'b0;
    end else begin
      alive_reg    <= 1'b1;
      mode_err_reg <= accept && !beat_ok;
      case (fsm_reg)
        S_IDLE, S_ABSORB: begin
          if (beat_ok) begin
            if (in_idle) mode_reg <= mode_i;
            state_reg      <= (in_idle ? '0 : state_reg) ^ absorb_vec;
            final_reg      <= 1'b0;
            pad_pend_reg   <= 1'b0;
            carry_pend_reg <= 1'b0;
            if (straddle) begin
              cnt_reg        <= '0;
              carry_data_reg <= carry_data;
              carry_keep_reg <= carry_keep;
              carry_last_reg <= last_i;
              carry_pend_reg <= 1'b1;
            end else if (fill) begin
              cnt_reg      <= '0;
              pad_pend_reg <= last_i;
            end else begin
              cnt_reg <= sum_cnt[7:0];
            end
          end
        end
        S_CARRY: begin
          state_reg      <= state_reg ^ SW'(carry_data_reg);
          cnt_reg        <= popcnt(carry_keep_reg);
          carry_pend_reg <= 1'b0;
        end
        S_PAD: begin
          state_reg    <= state_reg ^ pad_vec;
          pad_pend_reg <= 1'b0;
          final_reg    <= 1'b1;
        end
        S_PERM_WAIT: begin
          if (perm_done_i) state_reg <= perm_state_i;
        end
        S_DONE: final_reg <= 1'b0;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_absorb_unit.sv
// tb_absorb_unit: drives random messages into absorb_unit (DWIDTH=128) and
// compares the state presented at every permutation request against a
// byte-level sponge model (pad, split into rate blocks, XOR, substitute the
// bench-supplied permutation result). Also covers reset, illegal modes and
// reset while a permutation is outstanding.
module tb_absorb_unit;

  localparam int DW = 128;
  localparam int KW = DW / 8;

  logic            clk = 1'b0;
  logic            rst_n = 1'b0;
  logic [2:0]      mode_i = '0;
  logic [DW-1:0]   msg_i = '0;
  logic [KW-1:0]   keep_i = '0;
  logic            valid_i = 1'b0;
  logic            last_i = 1'b0;
  logic            ready_o;
  logic [1599:0]   state_o;
  logic            perm_req_o;
  logic            perm_done_i = 1'b0;
  logic [1599:0]   perm_state_i = '0;
  logic            done_o;
  logic            mode_err_o;

  int total_cnt = 0;
  int pass_cnt  = 0;
  int fail_cnt  = 0;
  int rates [6] = '{144, 136, 104, 72, 168, 136};
  logic [1599:0] last_final = '0;
`ifdef ABSORB_SHAKE_EN
  int max_mode = 5;
`else
  int max_mode = 3;
`endif

  absorb_unit #(.DWIDTH(DW), .KEEP_WIDTH(KW)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .mode_i       (mode_i),
    .msg_i        (msg_i),
    .keep_i       (keep_i),
    .valid_i      (valid_i),
    .last_i       (last_i),
    .ready_o      (ready_o),
    .state_o      (state_o),
    .perm_req_o   (perm_req_o),
    .perm_done_i  (perm_done_i),
    .perm_state_i (perm_state_i),
    .done_o       (done_o),
    .mode_err_o   (mode_err_o)
  );

  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total_cnt++;
    assert (obs === exp) pass_cnt++;
    else begin
      fail_cnt++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_state(input string tag, input logic [1599:0] obs, input logic [1599:0] exp);
    int idx;
    idx = 0;
    for (int i = 199; i >= 0; i--) if (obs[8*i +: 8] !== exp[8*i +: 8]) idx = i;
    total_cnt++;
    assert (obs === exp) pass_cnt++;
    else begin
      fail_cnt++;
      $error("FAIL %s first bad byte %0d observed=%02h expected=%02h", tag, idx, obs[8*idx +: 8], exp[8*idx +: 8]);
    end
  endtask

  function automatic logic [1599:0] rand_state();
    logic [1599:0] v;
    for (int j = 0; j < 50; j++) v[32*j +: 32] = $urandom;
    return v;
  endfunction

  // One message through the DUT; abort_at_perm returns while the first permutation is pending
  task automatic run_msg(input int mode, input int nbytes, input bit abort_at_perm);
    int r, nblk, sent, perms, dones, errs, delay, cyc, post, rem, cnt;
    bit all_sent, first, lst;
    logic [7:0] msg[$];
    logic [7:0] pb[$];
    logic [1599:0] exp_q[$];
    logic [1599:0] perm_q[$];
    logic [7:0] st[200];
    logic [1599:0] v;
    logic [7:0] dom;

    r = rates[mode];
    nblk = nbytes / r + 1;
    dom = (mode >= 4) ? 8'h1F : 8'h06;
    for (int i = 0; i < nbytes; i++) msg.push_back(8'($urandom));
    for (int i = 0; i < nblk * r; i++) pb.push_back(i < nbytes ? msg[i] : 8'h00);
    pb[nbytes] = pb[nbytes] ^ dom;
    pb[nblk*r-1] = pb[nblk*r-1] ^ 8'h80;
    for (int i = 0; i < 200; i++) st[i] = 8'h00;
    for (int k = 0; k < nblk; k++) begin
      for (int i = 0; i < r; i++) st[i] = st[i] ^ pb[k*r+i];
      for (int i = 0; i < 200; i++) v[8*i +: 8] = st[i];
      exp_q.push_back(v);
      v = rand_state();
      perm_q.push_back(v);
      for (int i = 0; i < 200; i++) st[i] = v[8*i +: 8];
    end

    sent = 0; perms = 0; dones = 0; errs = 0; delay = -1; cyc = 0; post = 0;
    all_sent = 0; first = 1;
    while (cyc < 2000) begin
      @(negedge clk);
      cyc++;
      perm_done_i = 1'b0;
      if (done_o) dones++;
      if (mode_err_o) errs++;
      if (dones > 0) begin
        post++;
        if (post > 2) break;
      end
      if (perm_req_o) begin
        if (delay < 0) delay = $urandom_range(3);
        if (delay == 0) begin
          if (abort_at_perm) begin
            valid_i = 1'b0;
            return;
          end
          if (perms < nblk) begin
            check_state($sformatf("perm%0d_state", perms), state_o, exp_q[perms]);
            perm_state_i = perm_q[perms];
          end else begin
            check_val("perm_count_overflow", perms + 1, nblk);
            perm_state_i = rand_state();
          end
          perm_done_i = 1'b1;
          perms++;
          delay = -1;
        end else begin
          delay--;
        end
      end
      valid_i = 1'b0;
      last_i  = 1'($urandom);
      keep_i  = KW'($urandom);
      mode_i  = 3'($urandom);
      for (int j = 0; j < DW / 32; j++) msg_i[32*j +: 32] = $urandom;
      if (ready_o && !all_sent && $urandom_range(3) != 0) begin
        rem = nbytes - sent;
        if (rem < KW || (rem == KW && $urandom_range(1) == 1)) begin
          cnt = rem; lst = 1;
        end else begin
          cnt = KW; lst = 0;
        end
        for (int j = 0; j < KW; j++) begin
          keep_i[j] = (j < cnt);
          if (j < cnt) msg_i[8*j +: 8] = msg[sent+j];
        end
        if (first) mode_i = 3'(mode);
        first   = 0;
        valid_i = 1'b1;
        last_i  = lst;
        sent    = sent + cnt;
        if (lst) all_sent = 1;
      end
    end
    valid_i = 1'b0;
    perm_done_i = 1'b0;
    check_val("perm_count", perms, nblk);
    check_val("done_pulses", dones, 1);
    check_val("mode_err_in_msg", errs, 0);
    check_state("final_state", state_o, perm_q[nblk-1]);
    check_val("ready_after_done", ready_o, 1);
    last_final = perm_q[nblk-1];
    $display("msg mode=%0d len=%0d blocks=%0d perms=%0d cycles=%0d", mode, nbytes, nblk, perms, cyc);
  endtask

  // Illegal-mode beat presented in IDLE: dropped, one-cycle mode_err_o
  task automatic bad_mode(input int m);
    @(negedge clk);
    check_val("bad_mode_ready", ready_o, 1);
    mode_i  = 3'(m);
    keep_i  = '1;
    last_i  = 1'($urandom);
    for (int j = 0; j < DW / 32; j++) msg_i[32*j +: 32] = $urandom;
    valid_i = 1'b1;
    @(negedge clk);
    valid_i = 1'b0;
    check_val($sformatf("mode_err_pulse_m%0d", m), mode_err_o, 1);
    check_val("bad_mode_perm_req", perm_req_o, 0);
    check_state("bad_mode_state", state_o, last_final);
    @(negedge clk);
    check_val("mode_err_clear", mode_err_o, 0);
    check_val("bad_mode_still_idle", ready_o, 1);
    $display("illegal beat mode=%0d", m);
  endtask

  initial begin
    // reset values
    repeat (2) @(negedge clk);
    check_state("reset_state", state_o, '0);
    check_val("reset_ready", ready_o, 0);
    check_val("reset_perm_req", perm_req_o, 0);
    check_val("reset_done", done_o, 0);
    check_val("reset_mode_err", mode_err_o, 0);
    rst_n = 1'b1;
    #1;
    check_val("ready_before_edge", ready_o, 0);
    @(negedge clk);
    check_val("ready_after_release", ready_o, 1);

    // directed: empty message, exact fill, straddle with carried last beat
    run_msg(1, 0, 0);
    run_msg(0, 144, 0);
    run_msg(1, 144, 0);
    run_msg(3, 72 * 2 + 5, 0);
    run_msg(2, 103, 0);

`ifdef ABSORB_SHAKE_EN
    run_msg(4, 3, 0);
    run_msg(5, 200, 0);
`else
    bad_mode(4);
    bad_mode(5);
`endif
    bad_mode(6);
    bad_mode(7);

    for (int t = 0; t < 10; t++) run_msg($urandom_range(max_mode), $urandom_range(400), 0);

    // reset while a permutation is outstanding; the late perm_done_i is ignored
    run_msg(3, 100, 1);
    rst_n = 1'b0;
    #1;
    check_state("abort_reset_state", state_o, '0);
    check_val("abort_reset_perm_req", perm_req_o, 0);
    check_val("abort_reset_ready", ready_o, 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    perm_state_i = rand_state();
    perm_done_i  = 1'b1;
    @(negedge clk);
    perm_done_i  = 1'b0;
    check_state("late_done_state", state_o, '0);
    check_val("late_done_done", done_o, 0);
    check_val("late_done_ready", ready_o, 1);
    check_val("late_done_perm_req", perm_req_o, 0);
    @(negedge clk);
    check_val("late_done_no_done", done_o, 0);
    $display("reset during permutation wait");
    last_final = '0;

    run_msg(1, 50, 0);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule

// File: doc/absorb_unit.md
ABSORB_UNIT -- requirements
Module: absorb_unit

Interface
REQ-001 SHALL have parameter DWIDTH, default 64, message beat width in bits, legal values 64/128/256.
REQ-002 SHALL have parameter KEEP_WIDTH, default DWIDTH/8, byte-enable width.
REQ-003 SHALL have ports: clk  input  1  sole clock; rst_n  input  1  asynchronous active-low reset.
REQ-004 SHALL have ports: mode_i  input  3  0=SHA3-224, 1=SHA3-256, 2=SHA3-384, 3=SHA3-512, 4=SHAKE128, 5=SHAKE256.
REQ-005 SHALL have ports: msg_i  input  DWIDTH  beat data; keep_i  input  KEEP_WIDTH  byte enables, contiguous from bit 0; valid_i  input  1; last_i  input  1; ready_o  output  1.
REQ-006 SHALL have ports: state_o  output  1600  current Keccak state; perm_req_o  output  1; perm_done_i  input  1; perm_state_i  input  1600  permuted state.
REQ-007 SHALL have ports: done_o  output  1  final absorb complete pulse; mode_err_o  output  1  illegal mode pulse.

Function
REQ-008 SHALL implement FSM IDLE, ABSORB, CARRY, PAD, PERM_WAIT, DONE.
REQ-009 SHALL latch mode_i on the first accepted beat in IDLE; rate bytes 144/136/104/72/168/136 for modes 0-5; mode_i ignored thereafter until IDLE.
REQ-010 SHALL accept a beat when valid_i && ready_o; ready_o high only in IDLE and ABSORB with no pending carry.
REQ-011 SHALL XOR accepted bytes into state_o at byte offset cnt (8-bit byte counter), state_o visible the cycle after acceptance, cnt += popcount(keep_i).
REQ-012 SHALL, when a beat straddles the rate boundary, absorb bytes up to rate, store the remainder plus its keep in a carry register, and enter PERM_WAIT then CARRY.
REQ-013 SHALL, when cnt reaches rate exactly, assert perm_req_o and enter PERM_WAIT; cnt resets to 0.
REQ-014 SHALL hold perm_req_o high in PERM_WAIT until perm_done_i; on perm_done_i load state from perm_state_i and deassert perm_req_o the next cycle.
REQ-015 SHALL ignore perm_done_i outside PERM_WAIT.
REQ-016 SHALL, in CARRY, XOR carry bytes at offset 0 in one cycle, set cnt to carry count, then go to PAD if the carried beat had last_i, else ABSORB.
REQ-017 SHALL, in PAD, XOR domain byte (0x06 SHA3, 0x1F SHAKE) at cnt and 0x80 at rate-1 (combined 0x86/0x9F when equal), then PERM_WAIT flagged final.
REQ-018 SHALL, when the last beat fills rate exactly, permute first, then pad an empty block at offset 0.
REQ-019 SHALL accept last_i with keep_i all-zero as an empty final beat (zero-length message legal).
REQ-020 SHALL, after the final permutation, enter DONE, pulse done_o one cycle, return to IDLE with state_o held for squeeze.
REQ-021 SHALL clear state to zero on the first accepted beat of a new message in IDLE before XOR.

Reset
REQ-022 SHALL on rst_n low asynchronously force FSM IDLE, state_o 0, cnt 0, carry 0, perm_req_o 0, done_o 0, mode_err_o 0, ready_o 0; ready_o rises the cycle after rst_n deasserts.
REQ-023 SHALL abandon any in-flight message, including PERM_WAIT, on reset; a late perm_done_i is then ignored.

Configuration
REQ-024 SHALL, with ABSORB_SHAKE_EN defined, support modes 4 and 5 as REQ-009/REQ-017.
REQ-025 SHALL, without ABSORB_SHAKE_EN, treat modes 4-7 as illegal: beat consumed and dropped, mode_err_o pulses one cycle, FSM stays IDLE; SHAKE logic absent.
REQ-026 SHALL treat modes 6-7 as illegal in both builds.

Verification
REQ-027 SHA3-256, DWIDTH=64, empty message (last_i, keep 0) -> state_o byte0 ^= 0x06, byte135 ^= 0x80, one perm_req_o, done_o pulse.
REQ-028 SHA3-256, DWIDTH=64, 17 full beats -> perm_req_o after beat 17 (cnt=136), second perm for pad block, done_o once.
REQ-029 SHA3-256, DWIDTH=128, 9 full beats -> beat 9 straddles: 8 bytes absorbed, 8 carried to offset 0 after perm_done_i, cnt=8.
REQ-030 SHAKE128 (ABSORB_SHAKE_EN), one beat keep=0x07 last -> bytes 0-2 absorbed, byte3 ^= 0x1F, byte167 ^= 0x80.
REQ-031 Reset asserted in PERM_WAIT, then perm_done_i pulse -> state_o 0, no done_o, ready_o high.
REQ-032 Without ABSORB_SHAKE_EN, mode_i=4 beat -> mode_err_o one-cycle pulse, state_o unchanged, perm_req_o low.
